// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional 2-entry skid, flush bubble and stall counter
module pipe_stage_reg #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] NOP_VAL = 32'h00000013,
  parameter bit          SKID_EN = 1'b1,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_VAL);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t            state, state_nx;
  logic [DATA_W-1:0] main_instr, skid_instr;
  logic [ADDR_W-1:0] main_addr, skid_addr;
  logic              in_fire, out_fire, load_in, load_skid, skid_to_main, clr_main;
  assign in_fire      = in_valid & in_ready & ~flush;
  assign out_fire     = out_valid & out_ready & ~stall & ~flush;
  assign load_in      = in_fire & (state == EMPTY | out_fire);
  assign load_skid    = SKID_EN & in_fire & (state == FULL) & ~out_fire;
  assign skid_to_main = (state == SKID) & out_fire;
  assign clr_main     = flush | (out_fire & ~in_fire & (state == FULL));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  always_comb
    state_nx = flush           ? EMPTY :
               state == EMPTY  ? (in_fire ? FULL : EMPTY) :
               state == FULL   ? (in_fire ? (out_fire ? FULL : SKID) : (out_fire ? EMPTY : FULL)) :
                                 (out_fire ? FULL : SKID);
  always_comb begin
    out_valid = state != EMPTY;
    out_instr = main_instr;
    out_addr  = main_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_instr <= NOP;
      main_addr  <= '0;
      skid_instr <= '0;
      skid_addr  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (clr_main) begin
        main_instr <= NOP;
        main_addr  <= '0;
      end else if (load_in) begin
        main_instr <= in_instr;
        main_addr  <= in_addr;
      end else if (skid_to_main) begin
        main_instr <= skid_instr;
        main_addr  <= skid_addr;
      end
      if (flush) begin
        skid_instr <= '0;
        skid_addr  <= '0;
      end else if (load_skid) begin
        skid_instr <= in_instr;
        skid_addr  <= in_addr;
      end
      if (stall & out_valid & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  generate
    if (SKID_EN) begin : g_skid
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= state_nx != SKID;
      assign in_ready = rdy_q;
    end else begin : g_comb
      assign in_ready = rst_n & (~out_valid | (out_ready & ~stall));
    end
  endgenerate
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the IF/ID boundary and any later inter-stage boundary.
- Carries an instruction word and its address with a valid/ready handshake.
- Optional 2-entry skid buffer, so the upstream ready signal is driven from a register.
- Flush inserts a NOP bubble and outranks everything except reset; a saturating counter records stall cycles.

Parameters:
- DATA_W, 32, instruction/payload width
- ADDR_W, 32, address width
- NOP_VAL, 32'h00000013, bubble value driven on out_instr when empty/flushed/reset (ADDI x0,x0,0); truncated/zero-extended to DATA_W
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16, width of the stall counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream has a word
- in_ready  output  1  stage can accept a word this cycle
- in_instr  input  DATA_W  upstream instruction
- in_addr  input  ADDR_W  upstream instruction address
- flush  input  1  discard all held and incoming words (branch mispredict)
- stall  input  1  hazard hold; output is not consumed while high
- out_valid  output  1  out_instr/out_addr hold a real instruction
- out_ready  input  1  downstream accepts
- out_instr  output  DATA_W  held instruction, NOP_VAL when out_valid=0
- out_addr  output  ADDR_W  held address, 0 when out_valid=0
- stall_cnt  output  CNT_W  saturating count of cycles with stall=1 and out_valid=1

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready & !flush.
  - out_fire = out_valid & out_ready & !stall & !flush.
- Reset (async, any time incl. mid-transfer):
  - state=EMPTY, out_valid=0, out_instr=NOP_VAL, out_addr=0, skid cleared, stall_cnt=0.
  - in_ready=0 while rst_n=0; it rises on the first clk edge after release.
- Registers: main entry (drives outputs) and skid entry (used only when SKID_EN=1). Outputs are taken directly from main registers; there is no combinational path from in_* to out_*.
- Latency: 1 cycle. A word accepted at edge N appears on out_* after edge N, provided the stage was EMPTY or main was consumed at that edge.
- State machine (SKID_EN=1):
  - EMPTY: in_fire -> FULL (main<=in).
  - FULL, in_fire & out_fire -> FULL (main<=in).
  - FULL, in_fire & !out_fire -> SKID (skid<=in).
  - FULL, !in_fire & out_fire -> EMPTY (main<=NOP_VAL/0).
  - SKID, out_fire -> FULL (main<=skid). in_fire is impossible in SKID.
  - in_ready = (state != SKID), registered.
- SKID_EN=0:
  - in_ready = !out_valid | (out_ready & !stall), combinational.
  - SKID is unreachable; the skid register is optimised away.
- Ordering: strict FIFO. The skid word is never overtaken; no word is duplicated or dropped except by flush.
- Priority per edge: reset > flush > stall > normal.
  - flush=1: state<=EMPTY, main<=NOP_VAL/0, skid cleared; the concurrent in word is dropped even if in_valid=1; in_ready stays registered per state rule (=1 next cycle).
  - stall=1 (no flush): main and skid hold; still accepts into skid if FULL and in_ready=1.
- stall_cnt: increments when stall=1 & out_valid=1; saturates at 2^CNT_W-1; cleared only by reset (not by flush).

Test Plan:
- Reset: drive rst_n=0 mid-stream with SKID state -> out_valid=0, out_instr=32'h00000013, out_addr=0, stall_cnt=0; after release, in_ready=1 at the first edge.
- Streaming, out_ready=1: in words 0x00500093@0x0, 0x00108113@0x4 on consecutive cycles -> each appears one cycle later in order; in_ready stays 1.
- Back-pressure: hold out_ready=0 and feed 3 words A,B,C -> A in main, B in skid, in_ready=0, C held upstream. Then out_ready=1 -> out sequence A,B,C with no loss or duplication.
- Stall: stall=1 for 4 cycles with out_valid=1 and word 0x00208233@0x8 -> outputs frozen, stall_cnt=4. Release -> consumed next cycle.
- Flush in SKID state with in_valid=1 -> next cycle out_valid=0, out_instr=NOP, out_addr=0, in_ready=1; the incoming word never appears.
- SKID_EN=0, CNT_W=2: out_ready=0 -> in_ready=0 combinationally; 5 stall cycles -> stall_cnt saturates at 3.
